// File: rtl/four_to_one_rr_collector_pkg.sv
// Shared constants and FSM encoding for the four-channel round-robin collector.
package four_to_one_rr_collector_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 2;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

endpackage

// File: rtl/four_to_one_rr_collector_rr_arbiter_4.sv
// Combinational 4-way round-robin pick: first requester at or after ptr, with wrap.
module rr_arbiter_4
    import four_to_one_rr_collector_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [SEL_W-1:0]  pick,
    output logic              any
);

    logic [SEL_W-1:0] idx;

    // Walk the offsets from far to near so the nearest requester overwrites the rest.
    always_comb begin
        pick = '0;
        any  = 1'b0;
        idx  = ptr;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = ptr + SEL_W'(k);
            if (req[idx]) begin
                pick = idx;
                any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/four_to_one_rr_collector.sv
// Four valid/ready channels collected onto one registered stream, round-robin
// with a packet lock; out_sel tags each beat with its source channel.
module four_to_one_rr_collector
    import four_to_one_rr_collector_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       in_valid,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_last,
    output logic [NUM_CH-1:0]       in_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_last,
    output logic [SEL_W-1:0]        out_sel,
    input  logic                    out_ready
);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] gnt_q, gnt_d;

    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_last_q;
    logic [SEL_W-1:0] out_sel_q;

    logic [SEL_W-1:0] arb_pick;
    logic             arb_any;
    logic [SEL_W-1:0] cand;
    logic             slot_free;
    logic             accept;
    logic [WIDTH-1:0] cand_data;
    logic             cand_last;

    rr_arbiter_4 u_arb (
        .req  (in_valid),
        .ptr  (ptr_q),
        .pick (arb_pick),
        .any  (arb_any)
    );

    // Candidate channel, handshake and data mux; in_ready is forced low while in reset.
    always_comb begin
        slot_free = !out_valid_q | out_ready;
        cand      = (state_q == ST_LOCKED) ? gnt_q : arb_pick;
        in_ready  = '0;
        if (rst_n && slot_free && ((state_q == ST_LOCKED) || arb_any)) begin
            in_ready[cand] = 1'b1;
        end
        accept    = |(in_valid & in_ready);
        cand_data = in_data[32'(cand) * WIDTH +: WIDTH];
        cand_last = in_last[cand];
    end

    // Lock on a multi-beat packet; release and advance the pointer on its last beat.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        if (accept) begin
            if (cand_last) begin
                state_d = ST_IDLE;
                ptr_d   = cand + SEL_W'(1);
            end else if (state_q == ST_IDLE) begin
                state_d = ST_LOCKED;
                gnt_d   = cand;
            end
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
        end
    end

    // Output register: load on accept, drain on out_ready, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_sel_q   <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= cand_data;
            out_last_q  <= cand_last;
            out_sel_q   <= cand;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_sel   = out_sel_q;

endmodule
